// File: rtl/io_sw_hex_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : io_sw_hex_ctrl
//  Description : Memory-mapped switch / seven-segment peripheral.
//                Switches are two-flop synchronised, debounced and their
//                debounced rising edges are latched as sticky W1C flags.
//                Digits are decoded from a CPU-written nibble register with
//                per-digit enable and blink masks.
//  Ports       : i_clk, i_rst      - clock, async active-high reset
//                i_sw              - raw switches (asynchronous)
//                i_wr_en/i_rd_en   - register write / read strobes
//                i_addr, i_wdata   - register index, write data
//                o_rdata           - registered read data
//                o_rd_valid        - read data valid (i_rd_en delayed 1)
//                o_hex             - active-low segments {g..a} per digit
//  Registers   : 0 SW_STATUS (RO), 1 HEX_DATA (RW), 2 HEX_CTRL (RW),
//                3 SW_EDGE (RO, write-1-to-clear)
//  Revision    : 1.0 - initial release
// ============================================================================
module io_sw_hex_ctrl #(
    parameter int N_SW       = 16,
    parameter int N_HEX      = 8,
    parameter int DEB_CYCLES = 4,
    parameter int BLINK_DIV  = 25000000
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic [N_SW-1:0]      i_sw,
    input  logic                 i_wr_en,
    input  logic                 i_rd_en,
    input  logic [1:0]           i_addr,
    input  logic [31:0]          i_wdata,
    output logic [31:0]          o_rdata,
    output logic                 o_rd_valid,
    output logic [7*N_HEX-1:0]   o_hex
);

    localparam int CNT_W = $clog2(DEB_CYCLES + 1);
    localparam int BLK_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

    localparam logic [CNT_W-1:0] DEB_MAX = CNT_W'(DEB_CYCLES - 1);
    localparam logic [BLK_W-1:0] BLK_MAX = BLK_W'(BLINK_DIV - 1);

    localparam logic [1:0] ADDR_SW_STATUS = 2'd0;
    localparam logic [1:0] ADDR_HEX_DATA  = 2'd1;
    localparam logic [1:0] ADDR_HEX_CTRL  = 2'd2;
    localparam logic [1:0] ADDR_SW_EDGE   = 2'd3;

    logic [N_SW-1:0]             sync1;
    logic [N_SW-1:0]             sync2;
    logic [N_SW-1:0]             deb;
    logic [N_SW-1:0][CNT_W-1:0]  deb_cnt;
    logic [N_SW-1:0]             edge_flags;
    logic [4*N_HEX-1:0]          hex_data;
    logic [N_HEX-1:0]            en_mask;
    logic [N_HEX-1:0]            blink_mask;
    logic [BLK_W-1:0]            blink_cnt;
    logic                        blink_phase;

    logic [N_SW-1:0]             differ;
    logic [N_SW-1:0]             flip;
    logic [N_SW-1:0]             rise;
    logic [N_SW-1:0]             edge_clr;
    logic [31:0]                 rd_mux;
    logic [7*N_HEX-1:0]          hex_next;

    function automatic logic [6:0] seg_decode(input logic [3:0] nib);
        case (nib)
            4'h0: seg_decode = 7'h40;
            4'h1: seg_decode = 7'h79;
            4'h2: seg_decode = 7'h24;
            4'h3: seg_decode = 7'h30;
            4'h4: seg_decode = 7'h19;
            4'h5: seg_decode = 7'h12;
            4'h6: seg_decode = 7'h02;
            4'h7: seg_decode = 7'h78;
            4'h8: seg_decode = 7'h00;
            4'h9: seg_decode = 7'h10;
            4'hA: seg_decode = 7'h08;
            4'hB: seg_decode = 7'h03;
            4'hC: seg_decode = 7'h46;
            4'hD: seg_decode = 7'h21;
            4'hE: seg_decode = 7'h06;
            default: seg_decode = 7'h0E;
        endcase
    endfunction

    // A switch flips only once its counter has seen DEB_CYCLES consecutive
    // differing cycles; a flip toward 1 is the rising edge that sets a flag.
    for (genvar i = 0; i < N_SW; i++) begin : g_deb
        assign differ[i] = sync2[i] ^ deb[i];
        assign flip[i]   = differ[i] && (deb_cnt[i] == DEB_MAX);
        assign rise[i]   = flip[i] && !deb[i];
    end

    assign edge_clr = (i_wr_en && (i_addr == ADDR_SW_EDGE)) ? i_wdata[N_SW-1:0] : '0;

    always_comb begin
        rd_mux = '0;
        case (i_addr)
            ADDR_SW_STATUS: rd_mux[N_SW-1:0] = deb;
            ADDR_HEX_DATA:  rd_mux[4*N_HEX-1:0] = hex_data;
            ADDR_HEX_CTRL: begin
                rd_mux[N_HEX-1:0]  = en_mask;
                rd_mux[8 +: N_HEX] = blink_mask;
            end
            default:        rd_mux[N_SW-1:0] = edge_flags;
        endcase
    end

    always_comb begin
        hex_next = '0;
        for (int k = 0; k < N_HEX; k++) begin
            if (!en_mask[k] || (blink_mask[k] && blink_phase)) begin
                hex_next[7*k +: 7] = 7'h7F;
            end else begin
                hex_next[7*k +: 7] = seg_decode(hex_data[4*k +: 4]);
            end
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            sync1       <= '0;
            sync2       <= '0;
            deb         <= '0;
            deb_cnt     <= '0;
            edge_flags  <= '0;
            hex_data    <= '0;
            en_mask     <= '1;
            blink_mask  <= '0;
            blink_cnt   <= '0;
            blink_phase <= 1'b0;
            o_rdata     <= '0;
            o_rd_valid  <= 1'b0;
            o_hex       <= '1;
        end else begin
            sync1 <= i_sw;
            sync2 <= sync1;
            deb   <= deb ^ flip;
            for (int i = 0; i < N_SW; i++) begin
                if (!differ[i] || flip[i]) begin
                    deb_cnt[i] <= '0;
                end else begin
                    deb_cnt[i] <= deb_cnt[i] + 1'b1;
                end
            end

            // Set takes priority over a simultaneous W1C on the same bit.
            edge_flags <= (edge_flags & ~edge_clr) | rise;

            if (i_wr_en && (i_addr == ADDR_HEX_DATA)) begin
                hex_data <= i_wdata[4*N_HEX-1:0];
            end
            if (i_wr_en && (i_addr == ADDR_HEX_CTRL)) begin
                en_mask    <= i_wdata[N_HEX-1:0];
                blink_mask <= i_wdata[8 +: N_HEX];
            end

            if (blink_cnt == BLK_MAX) begin
                blink_cnt   <= '0;
                blink_phase <= ~blink_phase;
            end else begin
                blink_cnt <= blink_cnt + 1'b1;
            end

            // Read mux sees pre-edge register values, so a same-cycle write
            // is not reflected in the returned data.
            o_rd_valid <= i_rd_en;
            if (i_rd_en) begin
                o_rdata <= rd_mux;
            end

            o_hex <= hex_next;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_io_sw_hex_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_io_sw_hex_ctrl
//  Description : Directed self-checking bench for io_sw_hex_ctrl with a
//                read-data scoreboard queue.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_io_sw_hex_ctrl;

    localparam int N_SW  = 16;
    localparam int N_HEX = 8;

    logic                clk;
    logic                rst;
    logic [N_SW-1:0]     sw;
    logic                wr_en;
    logic                rd_en;
    logic [1:0]          addr;
    logic [31:0]         wdata;
    logic [31:0]         rdata;
    logic                rd_valid;
    logic [7*N_HEX-1:0]  hex;

    int errors = 0;
    int checks = 0;
    logic [31:0] exp_q[$];

    localparam logic [6:0] SEG [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    io_sw_hex_ctrl #(
        .N_SW       (N_SW),
        .N_HEX      (N_HEX),
        .DEB_CYCLES (4),
        .BLINK_DIV  (4)
    ) dut (
        .i_clk      (clk),
        .i_rst      (rst),
        .i_sw       (sw),
        .i_wr_en    (wr_en),
        .i_rd_en    (rd_en),
        .i_addr     (addr),
        .i_wdata    (wdata),
        .o_rdata    (rdata),
        .o_rd_valid (rd_valid),
        .o_hex      (hex)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        addr = a; wdata = d; wr_en = 1'b1;
        tick();
        wr_en = 1'b0;
    endtask

    task automatic rd(input logic [1:0] a, input logic [31:0] e);
        addr = a; rd_en = 1'b1;
        exp_q.push_back(e);
        tick();
        rd_en = 1'b0;
    endtask

    function automatic logic [7*N_HEX-1:0] all_digits(input logic [6:0] s);
        logic [7*N_HEX-1:0] v;
        for (int k = 0; k < N_HEX; k++) v[7*k +: 7] = s;
        return v;
    endfunction

    // Scoreboard: each valid read response is matched against the oldest
    // expectation pushed when that read was issued.
    always @(posedge clk) begin
        #2;
        if (rd_valid) begin
            if (exp_q.size() == 0) begin
                chk("rd_valid_unexpected", 64'(rd_valid), 64'd0);
            end else begin
                chk("rdata", 64'(rdata), 64'(exp_q.pop_front()));
            end
        end
    end

    initial begin : stim
        logic [7*N_HEX-1:0] exp_hex;
        logic [31:0]        val;
        logic [6:0]         smp [20];
        logic               other_blank;
        int                 first;

        rst = 1'b1; sw = '0; wr_en = 1'b0; rd_en = 1'b0; addr = '0; wdata = '0;

        // Reset state
        tick();
        chk("rst_hex_blank", 64'(hex), 64'(all_digits(7'h7F)));
        chk("rst_rd_valid", 64'(rd_valid), 64'd0);
        chk("rst_rdata", 64'(rdata), 64'd0);
        rst = 1'b0;
        tick();
        chk("idle_hex_zero", 64'(hex), 64'(all_digits(7'h40)));

        rd(2'd0, 32'h0);
        chk("rd_valid_hi", 64'(rd_valid), 64'd1);
        tick();
        chk("rd_valid_lo", 64'(rd_valid), 64'd0);
        rd(2'd2, 32'h0000_00FF);
        rd(2'd1, 32'h0);

        // Hex decode of every nibble value
        wr(2'd1, 32'h89AB_CDEF);
        chk("hex_not_yet", 64'(hex), 64'(all_digits(7'h40)));
        tick();
        val = 32'h89AB_CDEF;
        for (int k = 0; k < N_HEX; k++) exp_hex[7*k +: 7] = SEG[val[4*k +: 4]];
        chk("hex_89abcdef", 64'(hex), 64'(exp_hex));
        rd(2'd1, 32'h89AB_CDEF);
        val = 32'h0123_4567;
        wr(2'd1, val);
        tick();
        for (int k = 0; k < N_HEX; k++) exp_hex[7*k +: 7] = SEG[val[4*k +: 4]];
        chk("hex_01234567", 64'(hex), 64'(exp_hex));

        // Same-register read and write on one edge: old value returned
        addr = 2'd1; wdata = 32'h1234_5678; wr_en = 1'b1; rd_en = 1'b1;
        exp_q.push_back(32'h0123_4567);
        tick();
        wr_en = 1'b0; rd_en = 1'b0;
        rd(2'd1, 32'h1234_5678);

        // 3-cycle glitch is rejected
        sw = 16'h0008;
        tick(3);
        sw = 16'h0000;
        tick(8);
        rd(2'd0, 32'h0);
        rd(2'd3, 32'h0);

        // Held switch appears on the 6th edge after the raw change
        sw = 16'h0008;
        tick(5);
        rd(2'd0, 32'h0);
        rd(2'd0, 32'h8);
        rd(2'd3, 32'h8);
        rd(2'd3, 32'h8);

        // W1C coinciding with a new debounced rise: set wins
        sw = 16'h0000;
        tick(10);
        rd(2'd0, 32'h0);
        rd(2'd3, 32'h8);
        sw = 16'h0008;
        tick(5);
        wr(2'd3, 32'h8);
        rd(2'd3, 32'h8);
        wr(2'd3, 32'h8);
        rd(2'd3, 32'h0);
        rd(2'd0, 32'h8);

        // HEX_CTRL unused bits read 0
        wr(2'd2, 32'hFFFF_FFFF);
        rd(2'd2, 32'h0000_FFFF);

        // Digit 0 disabled, others shown
        wr(2'd1, 32'h0);
        wr(2'd2, 32'h0000_01FE);
        tick();
        exp_hex = all_digits(7'h40);
        exp_hex[6:0] = 7'h7F;
        chk("ctrl_1fe", 64'(hex), 64'(exp_hex));

        // Digit 0 enabled and blinking, others disabled
        wr(2'd2, 32'h0000_0101);
        tick(2);
        other_blank = 1'b1;
        for (int j = 0; j < 20; j++) begin
            smp[j] = hex[6:0];
            if (hex[7*N_HEX-1:7] !== {(N_HEX-1){7'h7F}}) other_blank = 1'b0;
            tick();
        end
        chk("blink_others_blank", 64'(other_blank), 64'd1);
        first = 0;
        for (int j = 1; j < 6; j++) begin
            if (first == 0 && smp[j] !== smp[j-1]) first = j;
        end
        chk("blink_toggle_seen", 64'(first != 0), 64'd1);
        if (first == 0) first = 1;
        chk("blink_values", 64'({smp[first], smp[first-1]} == {7'h40, 7'h7F} ||
                                {smp[first], smp[first-1]} == {7'h7F, 7'h40}), 64'd1);
        for (int j = first; j < first + 12; j++) begin
            chk("blink_phase", 64'(smp[j]), 64'((((j - first) / 4) % 2 == 0) ? smp[first] : smp[first-1]));
        end
        rd(2'd2, 32'h0000_0101);

        // Asynchronous reset mid-debounce and mid-blink
        sw = 16'h0000;
        tick(10);
        sw = 16'h0010;
        tick(4);
        #2;
        rst = 1'b1;
        #1;
        chk("arst_hex", 64'(hex), 64'(all_digits(7'h7F)));
        chk("arst_rd_valid", 64'(rd_valid), 64'd0);
        chk("arst_rdata", 64'(rdata), 64'd0);
        tick(2);
        chk("arst_hold_hex", 64'(hex), 64'(all_digits(7'h7F)));
        sw = 16'h0000;
        rst = 1'b0;
        tick(10);
        chk("post_rst_hex", 64'(hex), 64'(all_digits(7'h40)));
        rd(2'd3, 32'h0);
        rd(2'd0, 32'h0);
        rd(2'd1, 32'h0);
        rd(2'd2, 32'h0000_00FF);

        // Drain outstanding reads with a bounded wait
        for (int j = 0; j < 5 && exp_q.size() != 0; j++) tick();
        chk("rd_queue_drained", 64'(exp_q.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
